// File: rtl/barrel_pkg.sv
// Shared constants and sizing helpers for the barrel multithreaded RV32 core.
// Pure declarations: no latency and no backpressure of its own.
package barrel_pkg;

    localparam int INSTR_BYTES      = 4;
    localparam int DEFAULT_RESET_PC = 0;

    function automatic int tid_width(input int num_threads);
        return (num_threads <= 2) ? 1 : $clog2(num_threads);
    endfunction

    function automatic int thread_mask_width(input int num_threads);
        return num_threads;
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Round-robin pick: first set bit of eligible, searching from cursor+1 with wrap.
// Combinational, zero latency; no backpressure, a new answer every cycle.
module rr_next_pick
    import barrel_pkg::*;
#(
    parameter int NUM_THREADS = 8,
    parameter int TID_WIDTH   = tid_width(NUM_THREADS)
) (
    input  logic [NUM_THREADS-1:0] eligible,
    input  logic [TID_WIDTH-1:0]   cursor,
    output logic                   found,
    output logic [TID_WIDTH-1:0]   sel_tid
);

    logic [TID_WIDTH-1:0]     start;
    logic [2*NUM_THREADS-1:0] doubled;
    logic [NUM_THREADS-1:0]   rotated;
    logic [TID_WIDTH-1:0]     offset;

    // Rotating by cursor+1 puts the cursor at the top bit, so it is checked last.
    always_comb begin
        start   = cursor + TID_WIDTH'(1);
        doubled = {eligible, eligible} >> start;
        rotated = doubled[NUM_THREADS-1:0];
        offset  = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = TID_WIDTH'(i);
            end
        end
        found   = |rotated;
        sel_tid = start + offset;
    end

endmodule

// File: rtl/barrel_fetch_sched.sv
// Per-thread PC store and round-robin fetch issue; one registered {tid, pc} per cycle.
// Latency one cycle from selection to fetch_*; stall freezes outputs, cursor and increments.
module barrel_fetch_sched
    import barrel_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH    = 32,
    parameter int                         NUM_THREADS      = 8,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC         = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [ADDRESS_WIDTH-1:0]   THREAD_PC_STRIDE = '0,
    parameter int                         TID_WIDTH        = tid_width(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic                     redirect_valid,
    input  logic [TID_WIDTH-1:0]     redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic                     halt_valid,
    input  logic [TID_WIDTH-1:0]     halt_tid,
    output logic                     fetch_valid,
    output logic [TID_WIDTH-1:0]     fetch_tid,
    output logic [ADDRESS_WIDTH-1:0] fetch_pc,
    output logic [NUM_THREADS-1:0]   active_mask
);

    localparam int MASK_W = thread_mask_width(NUM_THREADS);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(INSTR_BYTES);

    logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
    logic [MASK_W-1:0]        active_q, active_d;
    logic [TID_WIDTH-1:0]     cursor_q, cursor_d;
    logic                     fetch_valid_q, fetch_valid_d;
    logic [TID_WIDTH-1:0]     fetch_tid_q, fetch_tid_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

    logic [MASK_W-1:0]    halt_mask;
    logic [MASK_W-1:0]    eligible;
    logic                 pick_found;
    logic [TID_WIDTH-1:0] pick_tid;

    assign halt_mask = halt_valid ? (MASK_W'(1) << halt_tid) : '0;
    assign eligible  = thread_en & active_q & ~halt_mask;

    rr_next_pick #(
        .NUM_THREADS (NUM_THREADS),
        .TID_WIDTH   (TID_WIDTH)
    ) u_pick (
        .eligible (eligible),
        .cursor   (cursor_q),
        .found    (pick_found),
        .sel_tid  (pick_tid)
    );

    always_comb begin
        pc_d          = pc_q;
        active_d      = active_q & ~halt_mask;
        cursor_d      = cursor_q;
        fetch_valid_d = fetch_valid_q;
        fetch_tid_d   = fetch_tid_q;
        fetch_pc_d    = fetch_pc_q;

        if (redirect_valid) begin
            pc_d[redirect_tid] = redirect_pc;
        end

        if (!stall) begin
            if (pick_found) begin
                fetch_valid_d = 1'b1;
                fetch_tid_d   = pick_tid;
                cursor_d      = pick_tid;
                // A redirect landing on the issuing thread is bypassed straight to fetch.
                if (redirect_valid && (redirect_tid == pick_tid)) begin
                    fetch_pc_d     = redirect_pc;
                    pc_d[pick_tid] = redirect_pc + PC_STEP;
                end else begin
                    fetch_pc_d     = pc_q[pick_tid];
                    pc_d[pick_tid] = pc_q[pick_tid] + PC_STEP;
                end
            end else begin
                fetch_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_STRIDE;
            end
            active_q      <= '1;
            cursor_q      <= TID_WIDTH'(NUM_THREADS - 1);
            fetch_valid_q <= 1'b0;
            fetch_tid_q   <= '0;
            fetch_pc_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            active_q      <= active_d;
            cursor_q      <= cursor_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_tid_q   <= fetch_tid_d;
            fetch_pc_q    <= fetch_pc_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_tid   = fetch_tid_q;
    assign fetch_pc    = fetch_pc_q;
    assign active_mask = active_q;

endmodule

// File: tb/tb_barrel_fetch_sched.sv
// Directed table-driven bench for barrel_fetch_sched (8 threads, stride 0x100).
module tb_barrel_fetch_sched;

    localparam int NT = 8;
    localparam int AW = 32;
    localparam int TW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [NT-1:0] thread_en;
    logic          redirect_valid;
    logic [TW-1:0] redirect_tid;
    logic [AW-1:0] redirect_pc;
    logic          halt_valid;
    logic [TW-1:0] halt_tid;
    logic          fetch_valid;
    logic [TW-1:0] fetch_tid;
    logic [AW-1:0] fetch_pc;
    logic [NT-1:0] active_mask;

    always #5 clk = ~clk;

    barrel_fetch_sched #(
        .ADDRESS_WIDTH    (AW),
        .NUM_THREADS      (NT),
        .RESET_PC         (32'h0),
        .THREAD_PC_STRIDE (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .thread_en      (thread_en),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .fetch_valid    (fetch_valid),
        .fetch_tid      (fetch_tid),
        .fetch_pc       (fetch_pc),
        .active_mask    (active_mask)
    );

    typedef struct {
        logic          rst;
        logic          stall;
        logic [NT-1:0] en;
        logic          rv;
        logic [TW-1:0] rtid;
        logic [AW-1:0] rpc;
        logic          hv;
        logic [TW-1:0] htid;
        logic          ev;
        logic [TW-1:0] etid;
        logic [AW-1:0] epc;
        logic [NT-1:0] eact;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic [NT-1:0] en,
                                input logic rv, input int rt, input logic [AW-1:0] rp,
                                input logic hv, input int ht,
                                input logic ev, input int et, input logic [AW-1:0] ep,
                                input logic [NT-1:0] ea);
        vec_t v;
        v.rst = r;   v.stall = s;  v.en = en;
        v.rv = rv;   v.rtid = TW'(rt); v.rpc = rp;
        v.hv = hv;   v.htid = TW'(ht);
        v.ev = ev;   v.etid = TW'(et); v.epc = ep; v.eact = ea;
        return v;
    endfunction

    function automatic vec_t iss(input logic [NT-1:0] en, input int et,
                                 input logic [AW-1:0] ep, input logic [NT-1:0] ea);
        return mk(0, 0, en, 0, 0, 0, 0, 0, 1, et, ep, ea);
    endfunction

    function automatic vec_t hlt(input int ht, input logic ev, input int et,
                                 input logic [AW-1:0] ep, input logic [NT-1:0] ea);
        return mk(0, 0, 8'hFF, 0, 0, 0, 1, ht, ev, et, ep, ea);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst            = v.rst;
        stall          = v.stall;
        thread_en      = v.en;
        redirect_valid = v.rv;
        redirect_tid   = v.rtid;
        redirect_pc    = v.rpc;
        halt_valid     = v.hv;
        halt_tid       = v.htid;
        @(posedge clk);
        #1;
        chk("fetch_valid", idx, 32'(fetch_valid), 32'(v.ev));
        chk("fetch_tid",   idx, 32'(fetch_tid),   32'(v.etid));
        chk("fetch_pc",    idx, fetch_pc,         v.epc);
        chk("active_mask", idx, 32'(active_mask), 32'(v.eact));
    endtask

    initial begin
        // Reset, then full rotation with per-thread start PCs.
        tbl.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'hFF));
        for (int t = 0; t < NT; t++) tbl.push_back(iss(8'hFF, t, 32'(t) * 32'h100, 8'hFF));
        tbl.push_back(iss(8'hFF, 0, 32'h004, 8'hFF));
        // Sparse enable: 0 and 2 alternate, active stays full.
        tbl.push_back(iss(8'h05, 2, 32'h204, 8'hFF));
        tbl.push_back(iss(8'h05, 0, 32'h008, 8'hFF));
        tbl.push_back(iss(8'h05, 2, 32'h208, 8'hFF));
        tbl.push_back(iss(8'h05, 0, 32'h00C, 8'hFF));
        // Redirect tid 3 in its own issue cycle (bypass).
        tbl.push_back(iss(8'hFF, 1, 32'h104, 8'hFF));
        tbl.push_back(iss(8'hFF, 2, 32'h20C, 8'hFF));
        tbl.push_back(mk(0, 0, 8'hFF, 1, 3, 32'h2000, 0, 0, 1, 3, 32'h2000, 8'hFF));
        tbl.push_back(iss(8'hFF, 4, 32'h404, 8'hFF));
        tbl.push_back(iss(8'hFF, 5, 32'h504, 8'hFF));
        tbl.push_back(iss(8'hFF, 6, 32'h604, 8'hFF));
        tbl.push_back(iss(8'hFF, 7, 32'h704, 8'hFF));
        tbl.push_back(iss(8'hFF, 0, 32'h010, 8'hFF));
        tbl.push_back(iss(8'hFF, 1, 32'h108, 8'hFF));
        tbl.push_back(iss(8'hFF, 2, 32'h210, 8'hFF));
        tbl.push_back(iss(8'hFF, 3, 32'h2004, 8'hFF));
        // Three-cycle stall while redirecting tid 5.
        tbl.push_back(iss(8'hFF, 4, 32'h408, 8'hFF));
        tbl.push_back(mk(0, 1, 8'hFF, 1, 5, 32'h80, 0, 0, 1, 4, 32'h408, 8'hFF));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 1, 4, 32'h408, 8'hFF));
        tbl.push_back(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 1, 4, 32'h408, 8'hFF));
        tbl.push_back(iss(8'hFF, 5, 32'h080, 8'hFF));
        tbl.push_back(iss(8'hFF, 6, 32'h608, 8'hFF));
        tbl.push_back(iss(8'hFF, 7, 32'h708, 8'hFF));
        tbl.push_back(iss(8'hFF, 0, 32'h014, 8'hFF));
        // Halt tid 1 in the cycle it would issue; it never returns.
        tbl.push_back(hlt(1, 1, 2, 32'h214, 8'hFD));
        tbl.push_back(iss(8'hFF, 3, 32'h2008, 8'hFD));
        tbl.push_back(iss(8'hFF, 4, 32'h40C, 8'hFD));
        tbl.push_back(iss(8'hFF, 5, 32'h084, 8'hFD));
        tbl.push_back(iss(8'hFF, 6, 32'h60C, 8'hFD));
        tbl.push_back(iss(8'hFF, 7, 32'h70C, 8'hFD));
        tbl.push_back(iss(8'hFF, 0, 32'h018, 8'hFD));
        tbl.push_back(iss(8'hFF, 2, 32'h218, 8'hFD));
        // Halt the rest one per cycle; each halted thread is skipped immediately.
        tbl.push_back(hlt(3, 1, 4, 32'h410, 8'hF5));
        tbl.push_back(hlt(4, 1, 5, 32'h088, 8'hE5));
        tbl.push_back(hlt(5, 1, 6, 32'h610, 8'hC5));
        tbl.push_back(hlt(6, 1, 7, 32'h710, 8'h85));
        tbl.push_back(hlt(7, 1, 0, 32'h01C, 8'h05));
        tbl.push_back(hlt(0, 1, 2, 32'h21C, 8'h04));
        tbl.push_back(hlt(2, 0, 2, 32'h21C, 8'h00));
        tbl.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 32'h21C, 8'h00));
        // Reset mid-run, including over stall and redirect.
        tbl.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'hFF));
        tbl.push_back(mk(0, 0, 8'hFF, 1, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'hFFFF_FFFC, 8'hFF));
        tbl.push_back(mk(1, 1, 8'hFF, 1, 0, 32'h1234, 1, 0, 0, 0, 32'h0, 8'hFF));
        tbl.push_back(iss(8'hFF, 0, 32'h000, 8'hFF));
        // Lone thread issues back to back; PC wraps past the top of the space.
        tbl.push_back(mk(0, 0, 8'h01, 1, 0, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'hFFFF_FFFC, 8'hFF));
        tbl.push_back(iss(8'h01, 0, 32'h000, 8'hFF));
        tbl.push_back(iss(8'h01, 0, 32'h004, 8'hFF));
        // Halt and redirect on the same tid: it is skipped and deactivated.
        tbl.push_back(mk(0, 0, 8'h03, 1, 0, 32'h50, 1, 0, 1, 1, 32'h100, 8'hFE));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset released into a stall: nothing issues until the stall drops.
        apply(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'hFF), 100);
        apply(mk(0, 1, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 32'h0, 8'hFF), 101);
        apply(mk(0, 1, 8'hFF, 1, 2, 32'h40, 0, 0, 0, 0, 32'h0, 8'hFF), 102);
        apply(iss(8'hFF, 0, 32'h000, 8'hFF), 103);
        apply(iss(8'hFF, 1, 32'h100, 8'hFF), 104);
        apply(iss(8'hFF, 2, 32'h040, 8'hFF), 105);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
